qrst_req_arb: RTL and testbench
===============================

// Module: qrst_req_arb
// PURPOSE
//  Shares the single QICK reset/start sequencer (now/sync reset request, ack handshake) between NREQ
//  command sources (host AXI, xcom remote, local tProc). Round-robin grants one source at a time,
//  issues its now/sync request downstream, and completes the 4-phase handshake with the sequencer.
//  Returns a per-source done pulse. Sits between the command decoders and the reset/sync sequencer.
// PARAMETERS
//  NREQ    4   number of requesters (2..8)
//  TOUT_W  16  width of handshake timeout counter/config
// PORTS
//  t_clk_i          in   1             timing clock
//  t_rst_ni         in   1             async active-low reset
//  req_now_i        in   NREQ          per-source immediate-reset request (level, held until done)
//  req_sync_i       in   NREQ          per-source reset-on-next-sync-pulse request (level)
//  grant_o          out  NREQ          one-hot current owner; 0 when idle
//  req_done_o       out  NREQ          1-cycle pulse on owner bit when its transaction completes
//  busy_o           out  1             FSM not in IDLE
//  last_src_o       out  $clog2(NREQ)  index of last completed owner (RR pointer)
//  qrst_now_req_o   out  1             to sequencer: immediate reset request
//  qrst_sync_req_o  out  1             to sequencer: sync reset request
//  qrst_ack_i       in   1             from sequencer: ack, high from accept until request released
//  tout_cfg_i       in   TOUT_W        handshake timeout in cycles; 0 = disabled
//  err_clr_i        in   1             clears tout_err_o
//  tout_err_o       out  1             sticky timeout flag
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; RR pointer = NREQ-1 (first grant goes to source 0).
//  All outputs registered. FSM: IDLE -> ISSUE -> RELEASE -> DONE -> IDLE.
//  IDLE: pending = req_now_i | req_sync_i. Grant only if pending!=0 AND qrst_ack_i==0.
//   Winner = first set bit searching ptr+1, ptr+2, ... wrapping modulo NREQ.
//   Type latched at grant: sync if req_sync_i[winner] else now (sync wins when both set).
//   Request sampled at edge n -> grant_o and qrst_*_req_o high from cycle n+1 (ISSUE).
//  ISSUE: hold the latched request (exactly one of now/sync high). qrst_ack_i==1 -> RELEASE.
//  RELEASE: both qrst_*_req_o low; grant_o held. qrst_ack_i==0 -> DONE.
//  DONE (1 cycle): req_done_o[owner]=1; ptr and last_src_o <= owner; grant_o cleared next cycle; -> IDLE.
//  Committed transaction: requester dropping its request after grant does not abort; done still pulses.
//  New requests in non-IDLE states ignored until IDLE; a source still requesting after its done
//   pulse is re-arbitrated normally (it becomes lowest priority).
//  Simultaneous ack rise and fall cannot be skipped: each state samples one edge of ack.
//  Async reset mid-transaction: outputs drop to 0 immediately; downstream handshake completes on its own
//   (ack falls once request low); IDLE ack gate prevents a new grant before that.
// CONFIGURATION
//  QRST_ARB_TIMEOUT_EN defined: TOUT_W counter clears on entering ISSUE/RELEASE, increments each
//   cycle there. tout_cfg_i!=0 and count==tout_cfg_i-1 -> requests dropped, tout_err_o<=1,
//   go to DONE (done pulse still issued). tout_err_o clears on err_clr_i (set wins if same cycle).
//  Not defined: no counter; waits forever; tout_err_o tied 0; tout_cfg_i/err_clr_i ignored (ports kept).
// TESTING
//  1 req_now_i=4'b0100, ack rises 3 cyc after issue, falls 2 cyc after release -> grant_o=0100,
//    qrst_now_req_o=1 until ack, req_done_o=0100 one cycle, last_src_o=2.
//  2 req_now_i=4'b1111 held, ack model auto-responds -> grant order 0,1,2,3,0; one done pulse each.
//  3 req_now_i[1]=req_sync_i[1]=1 -> only qrst_sync_req_o asserted; done on bit 1.
//  4 qrst_ack_i forced 1 in IDLE with req_now_i=0001 -> no grant, busy_o=0; release ack -> grant next cycle.
//  5 TIMEOUT_EN, tout_cfg_i=10, ack never rises -> request drops after 10 ISSUE cycles, tout_err_o=1,
//    done pulses; err_clr_i=1 -> tout_err_o=0. Without macro: request held indefinitely, tout_err_o=0.
//  6 t_rst_ni low during RELEASE -> all outputs 0 same cycle; after release, ptr=NREQ-1, grant waits ack=0.

Source files
------------

// File: rtl/qrst_req_arb.sv
// Round-robin arbiter sharing the QICK reset/sync sequencer between NREQ command sources.
// Optional handshake timeout enabled by defining QRST_ARB_TIMEOUT_EN.
module qrst_req_arb #(
    parameter int NREQ   = 4,
    parameter int TOUT_W = 16
) (
    input  logic                     t_clk_i,
    input  logic                     t_rst_ni,
    input  logic [NREQ-1:0]          req_now_i,
    input  logic [NREQ-1:0]          req_sync_i,
    output logic [NREQ-1:0]          grant_o,
    output logic [NREQ-1:0]          req_done_o,
    output logic                     busy_o,
    output logic [$clog2(NREQ)-1:0]  last_src_o,
    output logic                     qrst_now_req_o,
    output logic                     qrst_sync_req_o,
    input  logic                     qrst_ack_i,
    input  logic [TOUT_W-1:0]        tout_cfg_i,
    input  logic                     err_clr_i,
    output logic                     tout_err_o
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE, S_DONE} state_t;

    state_t          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   owner_q;
    logic [NREQ-1:0] pending;
    logic [PW-1:0]   winner;

    // First pending source after the pointer, wrapping; the last owner ends up lowest priority.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] pend, input logic [PW-1:0] p);
        logic [PW-1:0] w;
        logic [PW-1:0] idx;
        logic          found;
        w     = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(p) + k) % NREQ);
            if (!found && pend[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign pending = req_now_i | req_sync_i;
    assign winner  = rr_pick(pending, ptr_q);

`ifdef QRST_ARB_TIMEOUT_EN
    logic [TOUT_W-1:0] tout_cnt_q;
    logic              tout_hit;

    assign tout_hit = (tout_cfg_i != '0) && (tout_cnt_q == tout_cfg_i - TOUT_W'(1));
`else
    logic unused_tout;

    assign unused_tout = ^{tout_cfg_i, err_clr_i};
    assign tout_err_o  = 1'b0;
`endif

    always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
        if (!t_rst_ni) begin
            state_q         <= S_IDLE;
            ptr_q           <= PW'(NREQ - 1);
            owner_q         <= '0;
            grant_o         <= '0;
            req_done_o      <= '0;
            busy_o          <= 1'b0;
            last_src_o      <= '0;
            qrst_now_req_o  <= 1'b0;
            qrst_sync_req_o <= 1'b0;
`ifdef QRST_ARB_TIMEOUT_EN
            tout_cnt_q      <= '0;
            tout_err_o      <= 1'b0;
`endif
        end else begin
            req_done_o <= '0;
`ifdef QRST_ARB_TIMEOUT_EN
            // Clear first so a timeout in the same cycle overrides it below.
            if (err_clr_i) tout_err_o <= 1'b0;
            tout_cnt_q <= tout_cnt_q + TOUT_W'(1);
`endif
            case (state_q)
                S_IDLE: begin
                    // Ack still high means the sequencer hasn't finished a previous handshake.
                    if ((pending != '0) && !qrst_ack_i) begin
                        owner_q         <= winner;
                        grant_o         <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
                        qrst_sync_req_o <= req_sync_i[winner];
                        qrst_now_req_o  <= !req_sync_i[winner];
                        busy_o          <= 1'b1;
                        state_q         <= S_ISSUE;
`ifdef QRST_ARB_TIMEOUT_EN
                        tout_cnt_q      <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    if (qrst_ack_i) begin
                        qrst_now_req_o  <= 1'b0;
                        qrst_sync_req_o <= 1'b0;
                        state_q         <= S_RELEASE;
`ifdef QRST_ARB_TIMEOUT_EN
                        tout_cnt_q      <= '0;
                    end else if (tout_hit) begin
                        qrst_now_req_o  <= 1'b0;
                        qrst_sync_req_o <= 1'b0;
                        tout_err_o      <= 1'b1;
                        req_done_o      <= grant_o;
                        state_q         <= S_DONE;
`endif
                    end
                end
                S_RELEASE: begin
                    if (!qrst_ack_i) begin
                        req_done_o <= grant_o;
                        state_q    <= S_DONE;
`ifdef QRST_ARB_TIMEOUT_EN
                    end else if (tout_hit) begin
                        tout_err_o <= 1'b1;
                        req_done_o <= grant_o;
                        state_q    <= S_DONE;
`endif
                    end
                end
                S_DONE: begin
                    grant_o    <= '0;
                    busy_o     <= 1'b0;
                    ptr_q      <= owner_q;
                    last_src_o <= owner_q;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qrst_req_arb.sv
// Directed bench for qrst_req_arb: reset, single/round-robin/sync transactions, ack gate,
// timeout (QRST_ARB_TIMEOUT_EN) and async reset mid-handshake.
module tb_qrst_req_arb;

    localparam int NREQ   = 4;
    localparam int TOUT_W = 16;

    logic              t_clk_i;
    logic              t_rst_ni;
    logic [NREQ-1:0]   req_now_i;
    logic [NREQ-1:0]   req_sync_i;
    logic [NREQ-1:0]   grant_o;
    logic [NREQ-1:0]   req_done_o;
    logic              busy_o;
    logic [1:0]        last_src_o;
    logic              qrst_now_req_o;
    logic              qrst_sync_req_o;
    logic              qrst_ack_i;
    logic [TOUT_W-1:0] tout_cfg_i;
    logic              err_clr_i;
    logic              tout_err_o;

    int n_cmp  = 0;
    int n_fail = 0;
    logic auto_ack = 1'b0;

    qrst_req_arb #(.NREQ(NREQ), .TOUT_W(TOUT_W)) dut (
        .t_clk_i         (t_clk_i),
        .t_rst_ni        (t_rst_ni),
        .req_now_i       (req_now_i),
        .req_sync_i      (req_sync_i),
        .grant_o         (grant_o),
        .req_done_o      (req_done_o),
        .busy_o          (busy_o),
        .last_src_o      (last_src_o),
        .qrst_now_req_o  (qrst_now_req_o),
        .qrst_sync_req_o (qrst_sync_req_o),
        .qrst_ack_i      (qrst_ack_i),
        .tout_cfg_i      (tout_cfg_i),
        .err_clr_i       (err_clr_i),
        .tout_err_o      (tout_err_o)
    );

    initial begin
        t_clk_i = 1'b0;
        forever #5 t_clk_i = ~t_clk_i;
    end

    // Sequencer model: ack follows the request one cycle later.
    always begin
        @(posedge t_clk_i);
        #1;
        if (auto_ack) qrst_ack_i = qrst_now_req_o | qrst_sync_req_o;
    end

    task automatic step();
        @(posedge t_clk_i);
        #1;
    endtask

    task automatic do_reset();
        t_rst_ni   = 1'b0;
        req_now_i  = '0;
        req_sync_i = '0;
        qrst_ack_i = 1'b0;
        err_clr_i  = 1'b0;
        tout_cfg_i = '0;
        step();
        step();
        t_rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        t_rst_ni   = 1'b0;
        req_now_i  = '0;
        req_sync_i = '0;
        qrst_ack_i = 1'b0;
        err_clr_i  = 1'b0;
        tout_cfg_i = '0;
        step();
        n_cmp++;
        if ({grant_o, req_done_o, busy_o, last_src_o, qrst_now_req_o, qrst_sync_req_o, tout_err_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: grant=%b done=%b busy=%b last=%0d now=%b sync=%b err=%b, need all 0",
                     grant_o, req_done_o, busy_o, last_src_o, qrst_now_req_o, qrst_sync_req_o, tout_err_o);
        end
        t_rst_ni = 1'b1;
        step();
        n_cmp++;
        if (busy_o !== 1'b0 || grant_o !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b grant=%b, need 0/0000", busy_o, grant_o);
        end
    endtask

    task automatic test_single_now();
        req_now_i = 4'b0100;
        step();
        n_cmp++;
        if (grant_o !== 4'b0100 || qrst_now_req_o !== 1'b1 || qrst_sync_req_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_issue: grant=%b now=%b sync=%b busy=%b, need 0100/1/0/1",
                     grant_o, qrst_now_req_o, qrst_sync_req_o, busy_o);
        end
        step();
        step();
        qrst_ack_i = 1'b1;
        n_cmp++;
        if (qrst_now_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_hold: now=%b, need 1", qrst_now_req_o);
        end
        step();
        n_cmp++;
        if (qrst_now_req_o !== 1'b0 || grant_o !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_release: now=%b grant=%b, need 0/0100", qrst_now_req_o, grant_o);
        end
        req_now_i = '0;
        step();
        qrst_ack_i = 1'b0;
        step();
        n_cmp++;
        if (req_done_o !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_done: done=%b, need 0100", req_done_o);
        end
        step();
        n_cmp++;
        if (req_done_o !== '0 || grant_o !== '0 || busy_o !== 1'b0 || last_src_o !== 2'd2) begin
            n_fail++;
            $display("FAIL single_end: done=%b grant=%b busy=%b last=%0d, need 0000/0000/0/2",
                     req_done_o, grant_o, busy_o, last_src_o);
        end
    endtask

    task automatic test_round_robin();
        int exp_idx [5] = '{0, 1, 2, 3, 0};
        logic [NREQ-1:0] exp_oh;
        int cnt;
        do_reset();
        req_now_i = 4'b1111;
        auto_ack  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_oh = 4'b0001 << exp_idx[i];
            cnt = 0;
            while (req_done_o == '0 && cnt < 20) begin
                step();
                cnt++;
            end
            n_cmp++;
            if (req_done_o !== exp_oh || grant_o !== exp_oh) begin
                n_fail++;
                $display("FAIL rr_done_%0d: done=%b grant=%b, need %b", i, req_done_o, grant_o, exp_oh);
            end
            if (i == 4) req_now_i = '0;
            step();
            n_cmp++;
            if (req_done_o !== '0 || last_src_o !== 2'(exp_idx[i])) begin
                n_fail++;
                $display("FAIL rr_after_%0d: done=%b last=%0d, need 0000/%0d", i, req_done_o, last_src_o, exp_idx[i]);
            end
        end
        step();
        n_cmp++;
        if (grant_o !== '0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_idle: grant=%b busy=%b, need 0000/0", grant_o, busy_o);
        end
        auto_ack   = 1'b0;
        qrst_ack_i = 1'b0;
    endtask

    task automatic test_sync_wins();
        req_now_i  = 4'b0010;
        req_sync_i = 4'b0010;
        step();
        n_cmp++;
        if (grant_o !== 4'b0010 || qrst_sync_req_o !== 1'b1 || qrst_now_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_issue: grant=%b sync=%b now=%b, need 0010/1/0", grant_o, qrst_sync_req_o, qrst_now_req_o);
        end
        qrst_ack_i = 1'b1;
        step();
        req_now_i  = '0;
        req_sync_i = '0;
        qrst_ack_i = 1'b0;
        step();
        n_cmp++;
        if (req_done_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL sync_done: done=%b, need 0010", req_done_o);
        end
        step();
        n_cmp++;
        if (last_src_o !== 2'd1) begin
            n_fail++;
            $display("FAIL sync_last: last=%0d, need 1", last_src_o);
        end
    endtask

    task automatic test_ack_gate();
        qrst_ack_i = 1'b1;
        req_now_i  = 4'b0001;
        step();
        step();
        n_cmp++;
        if (grant_o !== '0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL gate_blocked: grant=%b busy=%b, need 0000/0", grant_o, busy_o);
        end
        qrst_ack_i = 1'b0;
        step();
        n_cmp++;
        if (grant_o !== 4'b0001 || busy_o !== 1'b1 || qrst_now_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL gate_grant: grant=%b busy=%b now=%b, need 0001/1/1", grant_o, busy_o, qrst_now_req_o);
        end
        req_now_i  = '0;
        qrst_ack_i = 1'b1;
        step();
        qrst_ack_i = 1'b0;
        step();
        n_cmp++;
        if (req_done_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL gate_done: done=%b, need 0001", req_done_o);
        end
        step();
    endtask

    task automatic test_timeout();
        tout_cfg_i = 16'd10;
        req_now_i  = 4'b1000;
        step();
        n_cmp++;
        if (grant_o !== 4'b1000 || qrst_now_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL tout_issue: grant=%b now=%b, need 1000/1", grant_o, qrst_now_req_o);
        end
`ifdef QRST_ARB_TIMEOUT_EN
        for (int i = 0; i < 9; i++) begin
            step();
            n_cmp++;
            if (qrst_now_req_o !== 1'b1 || tout_err_o !== 1'b0) begin
                n_fail++;
                $display("FAIL tout_wait_%0d: now=%b err=%b, need 1/0", i, qrst_now_req_o, tout_err_o);
            end
        end
        step();
        n_cmp++;
        if (qrst_now_req_o !== 1'b0 || req_done_o !== 4'b1000 || tout_err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL tout_fire: now=%b done=%b err=%b, need 0/1000/1", qrst_now_req_o, req_done_o, tout_err_o);
        end
        req_now_i = '0;
        step();
        n_cmp++;
        if (tout_err_o !== 1'b1 || req_done_o !== '0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL tout_sticky: err=%b done=%b busy=%b, need 1/0000/0", tout_err_o, req_done_o, busy_o);
        end
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        n_cmp++;
        if (tout_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL tout_clear: err=%b, need 0", tout_err_o);
        end
`else
        for (int i = 0; i < 15; i++) step();
        n_cmp++;
        if (qrst_now_req_o !== 1'b1 || tout_err_o !== 1'b0 || grant_o !== 4'b1000) begin
            n_fail++;
            $display("FAIL notout_hold: now=%b err=%b grant=%b, need 1/0/1000", qrst_now_req_o, tout_err_o, grant_o);
        end
        req_now_i  = '0;
        qrst_ack_i = 1'b1;
        step();
        qrst_ack_i = 1'b0;
        step();
        n_cmp++;
        if (req_done_o !== 4'b1000 || tout_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL notout_done: done=%b err=%b, need 1000/0", req_done_o, tout_err_o);
        end
        step();
`endif
        tout_cfg_i = '0;
    endtask

    task automatic test_async_reset();
        req_now_i = 4'b0010;
        step();
        qrst_ack_i = 1'b1;
        step();
        req_now_i  = '0;
        qrst_ack_i = 1'b0;
        step();
        step();
        n_cmp++;
        if (last_src_o !== 2'd1) begin
            n_fail++;
            $display("FAIL arst_pre_last: last=%0d, need 1", last_src_o);
        end
        req_now_i = 4'b0100;
        step();
        qrst_ack_i = 1'b1;
        step();
        n_cmp++;
        if (grant_o !== 4'b0100 || qrst_now_req_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_release: grant=%b now=%b busy=%b, need 0100/0/1", grant_o, qrst_now_req_o, busy_o);
        end
        t_rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({grant_o, req_done_o, busy_o, last_src_o, qrst_now_req_o, qrst_sync_req_o, tout_err_o} !== '0) begin
            n_fail++;
            $display("FAIL arst_outputs: grant=%b done=%b busy=%b last=%0d now=%b sync=%b, need all 0",
                     grant_o, req_done_o, busy_o, last_src_o, qrst_now_req_o, qrst_sync_req_o);
        end
        req_now_i = 4'b0110;
        #3;
        t_rst_ni = 1'b1;
        step();
        step();
        n_cmp++;
        if (grant_o !== '0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_gate: grant=%b busy=%b, need 0000/0", grant_o, busy_o);
        end
        qrst_ack_i = 1'b0;
        step();
        n_cmp++;
        if (grant_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL arst_ptr: grant=%b, need 0010", grant_o);
        end
        req_now_i  = '0;
        qrst_ack_i = 1'b1;
        step();
        qrst_ack_i = 1'b0;
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_single_now();
        test_round_robin();
        test_sync_wins();
        test_ack_gate();
        test_timeout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
